taxi_i2c_target_regs: RTL and testbench

// I2C target (responder) for the board-management I2C bus: the other end of an I2C master.

---
 rtl/taxi_i2c_target_regs.sv | 201 ++++++++++++++++++++
 tb/tb_taxi_i2c_target_regs.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_i2c_target_regs.sv
// I2C target with a 7-bit device address and an 8-bit auto-incrementing register pointer.
// Bus reads/writes become single-cycle strobes on a byte-wide register port.
module taxi_i2c_target_regs #(
    parameter logic [6:0]  DEV_ADDR   = 7'h50,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        StIdle, StAddr, StIgnore, StAckA, StPtr, StAckP, StWr, StAckW, StRd, StMack
    } state_t;

    // Index 1 = SCL, index 0 = SDA
    logic [1:0]       meta, sync, filt, filt_q;
    logic [CNT_W-1:0] fcnt [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 2'b11;
            sync    <= 2'b11;
            filt    <= 2'b11;
            filt_q  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            meta   <= {scl_i, sda_i};
            sync   <= meta;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_MAX) begin
                    filt[i] <= sync[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, sda_f;

    assign sda_f     = filt[0];
    assign scl_rise  = filt[1] & ~filt_q[1];
    assign scl_fall  = ~filt[1] & filt_q[1];
    assign start_det = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
    assign stop_det  = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];

    state_t     state;
    logic [7:0] shift;
    logic [7:0] ptr;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       master_ack;
    logic       rd_wait;

    assign sda_o    = 1'b0;
    assign reg_addr = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            shift       <= '0;
            ptr         <= '0;
            bit_cnt     <= '0;
            rw          <= 1'b0;
            master_ack  <= 1'b0;
            rd_wait     <= 1'b0;
            sda_t       <= 1'b1;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            rd_wait   <= reg_rd_en;
            if (start_det) begin
                state   <= StAddr;
                bit_cnt <= '0;
                sda_t   <= 1'b1;
                busy    <= 1'b0;
                rd_wait <= 1'b0;
            end else if (stop_det) begin
                state   <= StIdle;
                bit_cnt <= '0;
                sda_t   <= 1'b1;
                busy    <= 1'b0;
                rd_wait <= 1'b0;
            end else begin
                // Read data arrives one clock after the request; ACK stays driven until then
                if (rd_wait) begin
                    shift <= {reg_rd_data[6:0], 1'b1};
                    sda_t <= reg_rd_data[7];
                end
                unique case (state)
                    StIdle, StIgnore: ;
                    StAddr, StPtr, StWr: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (state == StPtr) begin
                                    ptr <= {shift[6:0], sda_f};
                                end
                                if (state == StWr) begin
                                    reg_wr_data <= {shift[6:0], sda_f};
                                    reg_wr_en   <= 1'b1;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == StAddr) begin
                                if (shift[7:1] == DEV_ADDR) begin
                                    state <= StAckA;
                                    sda_t <= 1'b0;
                                    busy  <= 1'b1;
                                    rw    <= shift[0];
                                end else begin
                                    state <= StIgnore;
                                end
                            end else begin
                                state <= (state == StPtr) ? StAckP : StAckW;
                                sda_t <= 1'b0;
                            end
                        end
                    end
                    StAckA: begin
                        if (scl_fall) begin
                            if (rw) begin
                                state     <= StRd;
                                reg_rd_en <= 1'b1;
                            end else begin
                                state <= StPtr;
                                sda_t <= 1'b1;
                            end
                        end
                    end
                    StAckP: begin
                        if (scl_fall) begin
                            state <= StWr;
                            sda_t <= 1'b1;
                        end
                    end
                    StAckW: begin
                        if (scl_fall) begin
                            state <= StWr;
                            sda_t <= 1'b1;
                            ptr   <= ptr + 8'd1;
                        end
                    end
                    StRd: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state   <= StMack;
                                sda_t   <= 1'b1;
                                bit_cnt <= '0;
                            end else begin
                                sda_t <= shift[7];
                                shift <= {shift[6:0], 1'b1};
                            end
                        end
                    end
                    StMack: begin
                        if (scl_rise) begin
                            master_ack <= ~sda_f;
                        end else if (scl_fall) begin
                            if (master_ack) begin
                                state     <= StRd;
                                ptr       <= ptr + 8'd1;
                                reg_rd_en <= 1'b1;
                            end else begin
                                state <= StIgnore;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_taxi_i2c_target_regs.sv
// Bench for taxi_i2c_target_regs: bit-banged I2C master, register stub and a strobe scoreboard.
module tb_taxi_i2c_target_regs;

    localparam int Q  = 12;
    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       line;
    logic       sda_o, sda_t, reg_wr_en, reg_rd_en, busy;
    logic [7:0] reg_addr, reg_wr_data;
    logic [7:0] reg_rd_data = 8'h00;

    always #5 clk = ~clk;

    assign line = m_sda & (sda_t | sda_o);

    taxi_i2c_target_regs #(.DEV_ADDR(7'h50), .FILTER_LEN(FL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (m_scl),
        .sda_i      (line),
        .sda_o      (sda_o),
        .sda_t      (sda_t),
        .reg_addr   (reg_addr),
        .reg_wr_data(reg_wr_data),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_en  (reg_rd_en),
        .reg_rd_data(reg_rd_data),
        .busy       (busy)
    );

    // Register file stub: registered read, content = address ^ 0x5A
    always @(posedge clk) if (reg_rd_en) reg_rd_data <= reg_addr ^ 8'h5A;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    logic [7:0] mptr = 8'h00;
    logic       may_pull = 1'b0;
    logic       mon_en = 1'b0;
    int         hold = 0;

    task automatic push_wr(input logic [7:0] d);
        exp_q.push_back('{wr: 1'b1, addr: mptr, data: d});
        mptr = mptr + 8'd1;
    endtask

    task automatic push_rd();
        exp_q.push_back('{wr: 1'b0, addr: mptr, data: 8'h00});
    endtask

    always @(negedge clk) begin
        hold <= may_pull ? 12 : ((hold > 0) ? hold - 1 : 0);
        if (mon_en && rst_n) begin
            chk("sda_o_zero", sda_o, 1'b0);
            chk("sda_only_when_allowed", sda_t | may_pull | (hold != 0), 1'b1);
            if (reg_wr_en || reg_rd_en) begin
                chk("strobe_exclusive", reg_wr_en & reg_rd_en, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("strobe_expected", exp_q.size(), 1);
                end else begin
                    ev = exp_q.pop_front();
                    chk("strobe_kind_wr", reg_wr_en, ev.wr);
                    chk("strobe_addr", reg_addr, ev.addr);
                    if (ev.wr) chk("strobe_wr_data", reg_wr_data, ev.data);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, input logic glitch, output logic s);
        wait_clk(Q);
        m_sda = b;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        s = line;
        if (glitch) begin
            m_sda = ~b;
            wait_clk(FL - 1);
            m_sda = b;
        end
        wait_clk(Q);
        m_scl = 1'b0;
    endtask

    task automatic start_c();
        m_sda = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda = 1'b0;
        wait_clk(Q);
        m_scl = 1'b0;
    endtask

    task automatic stop_c();
        m_sda = 1'b0;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input logic glitch);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], glitch, s);
        may_pull = exp_ack;
        bit_io(1'b1, 1'b0, s);
        chk("ack_bit", s, exp_ack ? 1'b0 : 1'b1);
        may_pull = 1'b0;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic ack);
        logic [7:0] got;
        logic       s;
        may_pull = 1'b1;
        for (int i = 7; i >= 0; i--) bit_io(1'b1, 1'b0, got[i]);
        may_pull = 1'b0;
        chk("rd_byte", got, exp);
        if (ack) begin
            mptr = mptr + 8'd1;
            push_rd();
        end
        bit_io(~ack, 1'b0, s);
        if (!ack) begin
            wait_clk(10);
            chk("sda_released_after_nack", sda_t, 1'b1);
        end
    endtask

    task automatic wr_txn(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1,
                          input int nd, input logic glitch);
        start_c();
        send_byte(8'hA0, 1'b1, 1'b0);
        chk("busy_addressed", busy, 1'b1);
        mptr = p;
        send_byte(p, 1'b1, 1'b0);
        if (nd > 0) begin
            push_wr(d0);
            send_byte(d0, 1'b1, glitch);
        end
        if (nd > 1) begin
            push_wr(d1);
            send_byte(d1, 1'b1, glitch);
        end
        chk("busy_before_stop", busy, 1'b1);
        stop_c();
        wait_clk(10);
        chk("busy_after_stop", busy, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: bench did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       s;
        logic [7:0] t5d;
        logic [7:0] part;

        // Reset state
        wait_clk(3);
        chk("rst_sda_t", sda_t, 1'b1);
        chk("rst_sda_o", sda_o, 1'b0);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_wr_data", reg_wr_data, 8'h00);
        chk("rst_wr_en", reg_wr_en, 1'b0);
        chk("rst_rd_en", reg_rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        wait_clk(5);
        mon_en = 1'b1;

        // 1: two-byte write with pointer auto-increment
        wr_txn(8'h10, 8'hAB, 8'hCD, 2, 1'b0);
        chk("t1_ptr_after", reg_addr, 8'h12);
        chk("t1_wr_data_hold", reg_wr_data, 8'hCD);

        // 2: set pointer FF, repeated START, read two bytes across the wrap
        start_c();
        send_byte(8'hA0, 1'b1, 1'b0);
        mptr = 8'hFF;
        send_byte(8'hFF, 1'b1, 1'b0);
        start_c();
        push_rd();
        send_byte(8'hA1, 1'b1, 1'b0);
        chk("t2_busy_read", busy, 1'b1);
        recv_byte(8'hA5, 1'b1);
        recv_byte(8'h5A, 1'b0);
        stop_c();
        wait_clk(10);
        chk("t2_sda_idle", sda_t, 1'b1);
        chk("t2_ptr_after", reg_addr, 8'h00);
        chk("t2_busy_after", busy, 1'b0);

        // 3: other address is ignored
        start_c();
        send_byte(8'hA2, 1'b0, 1'b0);
        chk("t3_busy_addr", busy, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        chk("t3_busy_data", busy, 1'b0);
        stop_c();
        wait_clk(10);
        chk("t3_busy_stop", busy, 1'b0);

        // 4: short SDA glitches while SCL high: none may act as START/STOP
        m_sda = 1'b0;
        wait_clk(FL - 1);
        m_sda = 1'b1;
        wait_clk(Q);
        m_scl = 1'b0;
        send_byte(8'hA0, 1'b0, 1'b0);
        chk("t4_idle_busy", busy, 1'b0);
        stop_c();
        wait_clk(10);
        wr_txn(8'h20, 8'h5A, 8'h00, 1, 1'b1);
        chk("t4_ptr_after", reg_addr, 8'h21);

        // 5: reset during the 4th data bit of a read
        wr_txn(8'h30, 8'h00, 8'h00, 0, 1'b0);
        start_c();
        push_rd();
        send_byte(8'hA1, 1'b1, 1'b0);
        t5d = 8'h6A;
        may_pull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bit_io(1'b1, 1'b0, s);
            chk("t5_rd_bit", s, t5d[7-i]);
        end
        wait_clk(Q);
        m_sda = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        chk("t5_bit4_driven_low", line, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sda_t", sda_t, 1'b1);
        chk("t5_rst_ptr", reg_addr, 8'h00);
        mptr = 8'h00;
        wait_clk(3);
        rst_n = 1'b1;
        may_pull = 1'b0;
        wait_clk(Q);
        m_scl = 1'b0;
        stop_c();
        wait_clk(10);
        start_c();
        push_rd();
        send_byte(8'hA1, 1'b1, 1'b0);
        recv_byte(8'h5A, 1'b0);
        stop_c();
        wait_clk(10);

        // 6: STOP after 5 bits of a data byte discards it
        start_c();
        send_byte(8'hA0, 1'b1, 1'b0);
        mptr = 8'h40;
        send_byte(8'h40, 1'b1, 1'b0);
        part = 8'hC3;
        for (int i = 7; i >= 3; i--) bit_io(part[i], 1'b0, s);
        stop_c();
        wait_clk(10);
        chk("t6_busy_after_partial", busy, 1'b0);
        chk("t6_ptr_unchanged", reg_addr, 8'h40);
        wr_txn(8'h60, 8'h99, 8'h00, 1, 1'b0);
        chk("t6_ptr_after", reg_addr, 8'h61);
        chk("t6_wr_data", reg_wr_data, 8'h99);

        wait_clk(20);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
